// File: rtl/vc_output_allocator.sv
// Per-output-port VC allocator: round-robin grant held until the owner's tail flit.
// Optional ownership watchdog enabled by defining VC_ALLOC_TIMEOUT_EN.
module vc_output_allocator #(
  parameter int VC_NUM    = 4,
  parameter int TIMEOUT_W = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [VC_NUM-1:0]         req_i,
  input  logic [VC_NUM-1:0]         tail_i,
  input  logic                      out_rdy_i,
  output logic [VC_NUM-1:0]         alloc_o,
  output logic [$clog2(VC_NUM)-1:0] owner_o,
  output logic                      busy_o,
  output logic                      timeout_o
);

  localparam int PTR_W = $clog2(VC_NUM);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [VC_NUM-1:0]  alloc_q, alloc_d;
  logic [PTR_W-1:0]   win_idx;
  logic               win_found;
  logic               expire;

  // Modular add that stays inside 0..VC_NUM-1 for non-power-of-two VC_NUM.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p, input int inc);
    int s;
    s = int'(p) + inc;
    if (s >= VC_NUM) s = s - VC_NUM;
    return PTR_W'(s);
  endfunction

  // First requester found scanning upward from rr_ptr.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < VC_NUM; i++) begin
      if (!win_found && req_i[wrap_add(rr_ptr_q, i)]) begin
        win_found = 1'b1;
        win_idx   = wrap_add(rr_ptr_q, i);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    alloc_d  = alloc_q;
    case (state_q)
      IDLE: begin
        if (win_found && out_rdy_i) begin
          state_d  = BUSY;
          owner_d  = win_idx;
          rr_ptr_d = wrap_add(win_idx, 1);
          alloc_d  = VC_NUM'(1) << win_idx;
        end
      end
      BUSY: begin
        // Owner tail wins over a simultaneous watchdog expiry.
        if (tail_i[owner_q] || expire) begin
          state_d = IDLE;
          alloc_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        alloc_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      alloc_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      alloc_q  <= alloc_d;
    end
  end

`ifdef VC_ALLOC_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 timeout_q, timeout_d;

  // Expiry fires on the BUSY edge where the counter would reach all-ones.
  assign expire = (state_q == BUSY) && !tail_i[owner_q] && (&(cnt_q + TIMEOUT_W'(1)));

  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else begin
      cnt_d     = cnt_q + TIMEOUT_W'(1);
      timeout_d = expire;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_W;
  assign expire             = 1'b0;
  assign timeout_o          = 1'b0;
`endif

  assign alloc_o = alloc_q;
  assign owner_o = owner_q;
  assign busy_o  = (state_q == BUSY);

endmodule

// File: tb/tb_vc_output_allocator.sv
// Directed bench for vc_output_allocator: grant scoreboard plus immediate-assertion checks.
module tb_vc_output_allocator;

  localparam int VC_NUM = 4;
  localparam int PTR_W  = 2;

  logic              clk;
  logic              rst_n;
  logic [VC_NUM-1:0] req;
  logic [VC_NUM-1:0] tail;
  logic              out_rdy;
  logic [VC_NUM-1:0] alloc;
  logic [PTR_W-1:0]  owner;
  logic              busy;
  logic              timeout;

  logic [VC_NUM-1:0] exp_q[$];
  int                total = 0;
  int                bad   = 0;

  vc_output_allocator #(
    .VC_NUM   (VC_NUM),
    .TIMEOUT_W(3)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .req_i    (req),
    .tail_i   (tail),
    .out_rdy_i(out_rdy),
    .alloc_o  (alloc),
    .owner_o  (owner),
    .busy_o   (busy),
    .timeout_o(timeout)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: pop the expected grant and compare against alloc/owner/busy
  task automatic check_grant(input string tag);
    logic [VC_NUM-1:0] e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s: observed=%0h expected=<empty queue>", tag, alloc);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_alloc"}, 32'(alloc), 32'(e));
      check({tag, "_busy"}, 32'(busy), 32'd1);
      for (int k = 0; k < VC_NUM; k++)
        if (e[k]) check({tag, "_owner"}, 32'(owner), 32'(k));
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_alloc"}, 32'(alloc), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n   = 1'b0;
    req     = '0;
    tail    = '0;
    out_rdy = 1'b1;
    #2;
    check_idle("reset");
    check("reset_owner", 32'(owner), 32'd0);
    check("reset_timeout", 32'(timeout), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check_idle("post_reset");

    // round-robin with all VCs requesting
    req = 4'b1111;
    for (int i = 0; i < 5; i++) exp_q.push_back(VC_NUM'(1) << (i % VC_NUM));
    for (int i = 0; i < 5; i++) begin
      tail = exp_q[0];
      step();
      check_grant("rr_grant");
      step();
      check_idle("rr_gap");
      tail = '0;
    end
    req = '0;

    // backpressure: rr_ptr is now 1
    req     = 4'b0100;
    out_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_idle("bp_hold");
    end
    out_rdy = 1'b1;
    exp_q.push_back(4'b0100);
    step();
    check_grant("bp_grant");
    req  = '0;
    tail = 4'b0100;
    step();
    check_idle("bp_release");
    tail = '0;

    // pointer skip: rr_ptr is 3, only VC1 requests
    req = 4'b0010;
    exp_q.push_back(4'b0010);
    step();
    check_grant("skip_grant");

    // foreign tail and request drop keep the grant
    tail = 4'b0001;
    step();
    check("foreign_tail", 32'(alloc), 32'h2);
    tail = '0;
    req  = '0;
    step();
    check("req_drop", 32'(alloc), 32'h2);
    check("req_drop_owner", 32'(owner), 32'd1);
    tail = 4'b0010;
    req  = 4'b1111;
    step();
    check_idle("owner_tail");
    tail = '0;

    // rr_ptr should be 2 after granting VC1
    exp_q.push_back(4'b0100);
    step();
    check_grant("ptr_after_skip");
    req = '0;

`ifdef VC_ALLOC_TIMEOUT_EN
    for (int i = 0; i < 6; i++) begin
      step();
      check("wd_busy", 32'(busy), 32'd1);
      check("wd_no_pulse", 32'(timeout), 32'd0);
    end
    step();
    check_idle("wd_release");
    check("wd_pulse", 32'(timeout), 32'd1);
    step();
    check("wd_pulse_end", 32'(timeout), 32'd0);
    // forced release leaves rr_ptr at 3
    req = 4'b1111;
    exp_q.push_back(4'b1000);
    step();
    check_grant("wd_ptr_kept");
    req  = '0;
    tail = 4'b1000;
    step();
    tail = '0;
`else
    for (int i = 0; i < 20; i++) begin
      step();
      check("hold_alloc", 32'(alloc), 32'h4);
      check("hold_timeout", 32'(timeout), 32'd0);
    end
    tail = 4'b0100;
    step();
    check_idle("hold_release");
    tail = '0;
`endif

    // reset mid-packet with owner 2
    req = 4'b0100;
    exp_q.push_back(4'b0100);
    step();
    check_grant("pre_rst_grant");
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("async_rst");
    check("async_rst_owner", 32'(owner), 32'd0);
    check("async_rst_timeout", 32'(timeout), 32'd0);
    step();
    check_idle("rst_held");
    rst_n = 1'b1;
    req   = 4'b0001;
    exp_q.push_back(4'b0001);
    step();
    check_grant("post_rst_grant");
    req  = 4'b0110;
    tail = 4'b0001;
    step();
    check_idle("post_rst_release");
    tail = '0;
    // rr_ptr restarted from 0, so VC1 follows VC0
    exp_q.push_back(4'b0010);
    step();
    check_grant("post_rst_rr");
    req = '0;

    check("queue_drained", 32'(exp_q.size()), 32'd0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule
